// File: rtl/riscv_debug_pkg.sv
// Shared debug-subsystem types: the DMI request/response word, op/status encodings,
// requester indices and the DMI arbiter state encoding.
package riscv_debug_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  localparam logic [1:0] DMI_OP_NOP     = 2'd0;
  localparam logic [1:0] DMI_OP_READ    = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE   = 2'd2;

  localparam logic [1:0] DMI_STS_OK     = 2'd0;
  localparam logic [1:0] DMI_STS_FAILED = 2'd2;
  localparam logic [1:0] DMI_STS_BUSY   = 2'd3;

  localparam logic REQ_DTM       = 1'b0;
  localparam logic REQ_SYSBRIDGE = 1'b1;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [DMI_DATA_W-1:0] data;
    logic [1:0]            op;
  } dmi_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/dmi_port.sv
// DMIPort: request/response channel between a DMI master and the debug module.
interface DMIPort;
  import riscv_debug_pkg::*;

  logic req_valid;
  logic req_ready;
  dmi_t req;
  logic rsp_valid;
  logic rsp_ready;
  dmi_t rsp;

  modport master (output req_valid, req, rsp_ready, input req_ready, rsp_valid, rsp);
  modport slave  (input req_valid, req, rsp_ready, output req_ready, rsp_valid, rsp);
endinterface

// File: rtl/dmi_rr_picker.sv
// Two-way round-robin picker: the requester holding priority wins if it is valid.
module dmi_rr_picker (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic       grant
);

  assign grant = valid[prio] ? prio : ~prio;

endmodule

// File: rtl/dmi_arbiter.sv
// Arbitrates two DMI requesters onto one debug-module port, one transaction at a time.
// Optional DM response timeout enabled by defining DMI_ARB_TIMEOUT_EN.
module dmi_arbiter
  import riscv_debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int PRIO_RESET     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       test_mode,
  input  logic [1:0] req_valid_i,
  input  dmi_t [1:0] req_i,
  output logic [1:0] req_ready_o,
  output logic [1:0] rsp_valid_o,
  output dmi_t       rsp_o,
  input  logic [1:0] rsp_ready_i,
  DMIPort.master     dm
);

  arb_state_e state, state_nxt;
  logic       prio;
  logic       grant;
  logic       grant_q;
  logic       accept;
  logic       rsp_load;
  logic       dm_req_valid;
  logic       timeout;
  dmi_t       req_q;
  dmi_t       rsp_q;
  dmi_t       rsp_nxt;
  logic       unused_ok;

  dmi_rr_picker u_picker (
    .valid (req_valid_i),
    .prio  (prio),
    .grant (grant)
  );

  // Unsolicited or late DM responses are always accepted and simply dropped outside WAIT.
  assign dm.req_valid = dm_req_valid;
  assign dm.req       = req_q;
  assign dm.rsp_ready = 1'b1;

  assign unused_ok = ^{test_mode, dm.rsp.addr, TIMEOUT_CYCLES[0]};

`ifdef DMI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cnt <= '0;
    end else if (state == ARB_ISSUE || state == ARB_WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = (state == ARB_ISSUE || state == ARB_WAIT) &&
                   (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      prio    <= 1'(PRIO_RESET);
      grant_q <= REQ_DTM;
    end else begin
      state <= state_nxt;
      if (accept) begin
        prio    <= ~grant;
        grant_q <= grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)   req_q <= req_i[grant];
    if (rsp_load) rsp_q <= rsp_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    rsp_load     = 1'b0;
    rsp_nxt      = '0;
    dm_req_valid = 1'b0;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    rsp_o        = '0;
    // All outputs stay quiet while reset is held, whatever state is still registered.
    if (!rst) begin
      unique case (state)
        ARB_IDLE: begin
          if (|req_valid_i) begin
            accept             = 1'b1;
            req_ready_o[grant] = 1'b1;
            if (req_i[grant].op == DMI_OP_NOP) begin
              rsp_load  = 1'b1;
              state_nxt = ARB_RESP;
            end else begin
              state_nxt = ARB_ISSUE;
            end
          end
        end
        ARB_ISSUE: begin
          dm_req_valid = 1'b1;
          if (timeout) begin
            rsp_load   = 1'b1;
            rsp_nxt.op = DMI_STS_BUSY;
            state_nxt  = ARB_RESP;
          end else if (dm.req_ready) begin
            state_nxt = ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (timeout) begin
            rsp_load   = 1'b1;
            rsp_nxt.op = DMI_STS_BUSY;
            state_nxt  = ARB_RESP;
          end else if (dm.rsp_valid) begin
            rsp_load     = 1'b1;
            rsp_nxt.data = dm.rsp.data;
            rsp_nxt.op   = dm.rsp.op;
            state_nxt    = ARB_RESP;
          end
        end
        ARB_RESP: begin
          rsp_valid_o[grant_q] = 1'b1;
          rsp_o                = rsp_q;
          if (rsp_ready_i[grant_q]) state_nxt = ARB_IDLE;
        end
        default: state_nxt = ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmi_arbiter;
  import riscv_debug_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       test_mode;
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  logic [1:0] rsp_valid_o;
  logic [1:0] rsp_ready_i;
  dmi_t [1:0] req_i;
  dmi_t       rsp_o;

  int checks   = 0;
  int failures = 0;

  DMIPort dm ();

  dmi_arbiter #(.TIMEOUT_CYCLES(8), .PRIO_RESET(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .test_mode   (test_mode),
    .req_valid_i (req_valid_i),
    .req_i       (req_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_o       (rsp_o),
    .rsp_ready_i (rsp_ready_i),
    .dm          (dm)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic dmi_t mk(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    dmi_t r;
    r.addr = a;
    r.data = d;
    r.op   = op;
    return r;
  endfunction

  // Debug-module stub behaviour: response derived from the request it accepted.
  function automatic dmi_t dm_func(input dmi_t r);
    dmi_t o;
    o.addr = r.addr;
    o.data = 32'hDEADBEEF ^ {25'h0, r.addr ^ 7'h11} ^ r.data;
    o.op   = (r.addr[6:4] == 3'b111) ? DMI_STS_FAILED : DMI_STS_OK;
    return o;
  endfunction

  // DM stub: always ready; answers dm_lat cycles after the handshake cycle.
  int   dm_lat  = 0;
  logic dm_hs   = 1'b0;
  dmi_t dm_req_s;
  logic dm_pend = 1'b0;
  int   dm_wcnt = 0;
  dmi_t dm_presp;

  assign dm.req_ready = 1'b1;

  always @(negedge clk) begin
    dm_hs    = dm.req_valid & dm.req_ready;
    dm_req_s = dm.req;
  end

  always @(posedge clk) begin
    #1;
    dm.rsp_valid = 1'b0;
    if (dm_hs) begin
      dm_pend  = 1'b1;
      dm_wcnt  = dm_lat;
      dm_presp = dm_func(dm_req_s);
    end else if (dm_pend && dm_wcnt > 0) begin
      dm_wcnt--;
    end
    if (dm_pend && dm_wcnt == 0) begin
      dm.rsp_valid = 1'b1;
      dm.rsp       = dm_presp;
      dm_pend      = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drain();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      req_valid_i = 2'b00;
      rsp_ready_i = 2'b11;
      settle();
      if (rsp_valid_o != 2'b00) seen = 1'b1;
    end
    chk("drain_rsp_seen", 64'(seen), 64'd1);
  endtask

  logic [1:0] grants[$];
  logic [1:0] exp_grants[4];
  int         n_dm;
  dmi_t       exp_rsp;
  bit         seen;

  // transaction-level model state for the random run
  bit         m_busy;
  bit         m_owner;
  bit         m_nop;
  bit         m_prio;
  int         m_age;
  int         m_due;
  dmi_t       m_req;
  dmi_t       m_exp;
  logic       pick;
  logic [1:0] exp_rdy;

  initial begin
    rst         = 1'b1;
    test_mode   = 1'b0;
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b00;
    req_i[0]    = mk(7'h11, 32'h0, DMI_OP_READ);
    req_i[1]    = mk(7'h12, 32'h0, DMI_OP_READ);

    // reset state with both requesters pushing
    for (int i = 0; i < 2; i++) begin
      cyc();
      settle();
      chk("rst_req_ready", req_ready_o, 2'b00);
      chk("rst_rsp_valid", rsp_valid_o, 2'b00);
      chk("rst_dm_valid", dm.req_valid, 1'b0);
      chk("rst_rsp_o", rsp_o, '0);
    end

    // single read, DM answers the cycle after issue
    cyc(); rst = 1'b0; req_valid_i = 2'b00; settle();
    cyc();
    req_valid_i = 2'b01;
    req_i[0]    = mk(7'h11, 32'h0, DMI_OP_READ);
    rsp_ready_i = 2'b01;
    dm_lat      = 0;
    settle();
    chk("lat_accept", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00; settle();
    chk("lat_issue_dm_valid", dm.req_valid, 1'b1);
    chk("lat_issue_dm_addr", dm.req.addr, 7'h11);
    chk("lat_c1_rsp_valid", rsp_valid_o, 2'b00);
    cyc(); settle();
    chk("lat_c2_rsp_valid", rsp_valid_o, 2'b00);
    cyc(); settle();
    chk("lat_c3_rsp_valid", rsp_valid_o, 2'b01);
    chk("lat_c3_data", rsp_o.data, 32'hDEADBEEF);
    chk("lat_c3_op", rsp_o.op, DMI_STS_OK);
    cyc(); settle();
    chk("lat_c4_rsp_valid", rsp_valid_o, 2'b00);

    // both valid from reset: alternating grants, one dm issue per grant
    cyc(); rst = 1'b1; req_valid_i = 2'b00; settle();
    cyc();
    rst         = 1'b0;
    req_i[0]    = mk(7'h01, 32'h0, DMI_OP_READ);
    req_i[1]    = mk(7'h02, 32'h0, DMI_OP_READ);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b11;
    settle();
    n_dm = 0;
    grants.delete();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin cyc(); settle(); end
      if (req_ready_o != 2'b00) grants.push_back(req_ready_o);
      if (dm.req_valid) n_dm++;
    end
    exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
    chk("rr_grant_count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant_%0d", k), (k < grants.size()) ? grants[k] : 2'b00, exp_grants[k]);
    chk("rr_dm_issues", 64'(n_dm), 64'd4);

    // nop from requester 1 answered locally
    cyc(); req_valid_i = 2'b00; settle();
    cyc();
    req_valid_i = 2'b10;
    req_i[1]    = mk(7'h05, 32'h12345678, DMI_OP_NOP);
    rsp_ready_i = 2'b10;
    settle();
    chk("nop_accept", req_ready_o, 2'b10);
    chk("nop_c0_dm_valid", dm.req_valid, 1'b0);
    cyc(); req_valid_i = 2'b00; settle();
    chk("nop_rsp_valid", rsp_valid_o, 2'b10);
    chk("nop_rsp_data", rsp_o.data, 32'h0);
    chk("nop_rsp_op", rsp_o.op, DMI_STS_OK);
    chk("nop_c1_dm_valid", dm.req_valid, 1'b0);
    cyc(); settle();
    chk("nop_c2_rsp_valid", rsp_valid_o, 2'b00);
    chk("nop_c2_dm_valid", dm.req_valid, 1'b0);

    // response held back by requester; other requester's ready ignored
    cyc();
    req_valid_i = 2'b01;
    req_i[0]    = mk(7'h20, 32'h0000CAFE, DMI_OP_WRITE);
    rsp_ready_i = 2'b00;
    dm_lat      = 1;
    settle();
    chk("hold_accept", req_ready_o, 2'b01);
    exp_rsp = dm_func(mk(7'h20, 32'h0000CAFE, DMI_OP_WRITE));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(); req_valid_i = 2'b11; settle();
      if (rsp_valid_o != 2'b00) seen = 1'b1;
    end
    chk("hold_rsp_seen", rsp_valid_o, 2'b01);
    for (int i = 0; i < 10; i++) begin
      cyc(); rsp_ready_i = 2'b10; settle();
      chk("hold_rsp_valid", rsp_valid_o, 2'b01);
      chk("hold_rsp_data", rsp_o.data, exp_rsp.data);
      chk("hold_rsp_op", rsp_o.op, exp_rsp.op);
      chk("hold_req_ready", req_ready_o, 2'b00);
    end
    cyc(); rsp_ready_i = 2'b01; settle();
    chk("hold_release_rsp_valid", rsp_valid_o, 2'b01);
    cyc(); settle();
    chk("hold_idle_next_grant", req_ready_o, 2'b10);
    drain();

    // reset pulsed in WAIT; DM response lands afterwards and must vanish
    cyc();
    req_valid_i = 2'b01;
    req_i[0]    = mk(7'h30, 32'h0, DMI_OP_READ);
    rsp_ready_i = 2'b11;
    dm_lat      = 2;
    settle();
    chk("abort_accept", req_ready_o, 2'b01);
    cyc(); req_valid_i = 2'b00; settle();
    chk("abort_issue_dm_valid", dm.req_valid, 1'b1);
    cyc(); rst = 1'b1; settle();
    chk("abort_rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("abort_rst_dm_valid", dm.req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(); rst = 1'b0; settle();
      chk("abort_after_rsp_valid", rsp_valid_o, 2'b00);
      chk("abort_after_dm_valid", dm.req_valid, 1'b0);
    end
    cyc(); req_valid_i = 2'b11; dm_lat = 0; settle();
    chk("abort_prio_reset", req_ready_o, 2'b01);
    drain();

    // randomized traffic against the transaction-level model
    cyc(); rst = 1'b1; req_valid_i = 2'b00; settle();
    m_busy = 1'b0;
    m_prio = 1'b0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      rst         = 1'b0;
      req_valid_i = 2'($urandom);
      for (int r = 0; r < 2; r++)
        req_i[r] = mk(7'($urandom), $urandom, 2'($urandom_range(0, 2)));
      rsp_ready_i = 2'($urandom);
      settle();
      if (!m_busy) begin
        exp_rdy = 2'b00;
        pick    = 1'b0;
        if (req_valid_i != 2'b00) begin
          pick = (req_valid_i == 2'b11) ? m_prio : (req_valid_i[0] ? 1'b0 : 1'b1);
          exp_rdy[pick] = 1'b1;
        end
        chk("rnd_idle_req_ready", req_ready_o, exp_rdy);
        chk("rnd_idle_rsp_valid", rsp_valid_o, 2'b00);
        chk("rnd_idle_dm_valid", dm.req_valid, 1'b0);
        if (req_valid_i != 2'b00) begin
          m_busy  = 1'b1;
          m_owner = pick;
          m_req   = req_i[pick];
          m_nop   = (m_req.op == DMI_OP_NOP);
          m_exp   = m_nop ? '0 : dm_func(m_req);
          dm_lat  = $urandom_range(0, 3);
          m_due   = m_nop ? 1 : 3 + dm_lat;
          m_age   = 0;
          m_prio  = ~pick;
        end
      end else begin
        m_age++;
        chk("rnd_busy_req_ready", req_ready_o, 2'b00);
        chk("rnd_dm_valid", dm.req_valid, (!m_nop && m_age == 1));
        if (!m_nop && m_age == 1) chk("rnd_dm_req", dm.req, m_req);
        if (m_age < m_due) begin
          chk("rnd_early_rsp_valid", rsp_valid_o, 2'b00);
        end else begin
          chk("rnd_rsp_valid", rsp_valid_o, m_owner ? 2'b10 : 2'b01);
          chk("rnd_rsp_data", rsp_o.data, m_exp.data);
          chk("rnd_rsp_op", rsp_o.op, m_exp.op);
          if (rsp_ready_i[m_owner]) m_busy = 1'b0;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      cyc(); req_valid_i = 2'b00; rsp_ready_i = 2'b11; settle();
    end

`ifdef DMI_ARB_TIMEOUT_EN
    // silent DM: busy status after the timeout, late response discarded
    cyc();
    req_valid_i = 2'b01;
    req_i[0]    = mk(7'h11, 32'h0, DMI_OP_READ);
    rsp_ready_i = 2'b01;
    dm_lat      = 12;
    settle();
    chk("to_accept", req_ready_o, 2'b01);
    for (int i = 1; i <= 8; i++) begin
      cyc(); req_valid_i = 2'b00; settle();
      chk("to_wait_rsp_valid", rsp_valid_o, 2'b00);
    end
    cyc(); settle();
    chk("to_rsp_valid", rsp_valid_o, 2'b01);
    chk("to_rsp_op", rsp_o.op, DMI_STS_BUSY);
    chk("to_rsp_data", rsp_o.data, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(); settle();
      chk("to_late_rsp_valid", rsp_valid_o, 2'b00);
    end
    cyc();
    req_valid_i = 2'b10;
    req_i[1]    = mk(7'h12, 32'h0, DMI_OP_READ);
    rsp_ready_i = 2'b10;
    dm_lat      = 0;
    settle();
    chk("to_next_accept", req_ready_o, 2'b10);
    exp_rsp = dm_func(mk(7'h12, 32'h0, DMI_OP_READ));
    cyc(); req_valid_i = 2'b00; settle();
    cyc(); settle();
    cyc(); settle();
    chk("to_next_rsp_valid", rsp_valid_o, 2'b10);
    chk("to_next_rsp_data", rsp_o.data, exp_rsp.data);
    cyc(); settle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
